// File: rtl/coll_instr_gen.sv
// Collective-instruction generator: turns one collective request flit into a
// sequence of routed flits using runtime-writable communicator and rank tables.
module coll_instr_gen #(
    parameter int                FLIT_W       = 82,
    parameter int                CHILD_W      = 3,
    parameter int                NUM_PROCS    = 8,
    parameter int                RANK_W       = 9,
    parameter int                COMM_ENTRIES = 4,
    parameter int                MAX_FANOUT   = 4,
    parameter logic [RANK_W-1:0] MY_COORD     = '0,
    parameter int                COMM_W       = 26 + MAX_FANOUT*RANK_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLIT_W-1:0]               in_flit,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [FLIT_W+CHILD_W-1:0]       out_flit,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            cfg_comm_we,
    input  logic [$clog2(COMM_ENTRIES)-1:0] cfg_comm_addr,
    input  logic [COMM_W-1:0]               cfg_comm_data,
    input  logic                            cfg_rank_we,
    input  logic [$clog2(NUM_PROCS)-1:0]    cfg_rank_addr,
    input  logic [RANK_W-1:0]               cfg_rank_data,
    output logic                            err
);
    localparam int CA_W   = $clog2(COMM_ENTRIES);
    localparam int RA_W   = $clog2(NUM_PROCS);
    localparam int LG_LSB = MAX_FANOUT*RANK_W;
    localparam int NC_LSB = LG_LSB + 4;
    localparam int PR_LSB = NC_LSB + 3;
    localparam int LR_LSB = PR_LSB + RANK_W;
    localparam int V_BIT  = LR_LSB + RANK_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; once out_valid rises, out_flit is held until that transfer.
    logic [1:0]        state;
    logic [COMM_W-1:0] comm_table [COMM_ENTRIES];
    logic [RANK_W-1:0] rank_table [NUM_PROCS];
    logic [53:0]       req_q;
    logic [COMM_W-1:0] ent_q;
    logic [3:0]        count_q;
    logic [3:0]        step_q;
    logic              err_q;

    logic [7:0]        lk_ctx;
    logic [COMM_W-1:0] lk_ent;
    logic [3:0]        lk_count;
    logic              lk_bad;

    assign lk_ctx = req_q[53:46];
    assign lk_ent = comm_table[lk_ctx[CA_W-1:0]];

    always_comb begin
        lk_count = 4'd0;
        case (req_q[37:36])
            2'b00:   lk_count = 4'd1;
            2'b01:   lk_count = {1'b0, lk_ent[NC_LSB +: 3]};
            2'b10:   lk_count = lk_ent[LG_LSB +: 4];
            default: lk_count = 4'd1;
        endcase
    end

    assign lk_bad = (32'(lk_ctx) >= 32'(COMM_ENTRIES)) || !lk_ent[V_BIT] || (lk_count == 4'd0);

    logic [RANK_W-1:0] e_local;
    logic [RANK_W-1:0] e_parent;
    logic [2:0]        e_nch;
    logic [3:0]        e_lg;
    logic [RANK_W-1:0] lg_mask;
    logic [RANK_W-1:0] bc_rank;
    logic [RANK_W-1:0] target;
    logic [RANK_W-1:0] dst_coord;
    logic [7:0]        out_tag;

    assign e_local  = ent_q[LR_LSB +: RANK_W];
    assign e_parent = ent_q[PR_LSB +: RANK_W];
    assign e_nch    = ent_q[NC_LSB +: 3];
    assign e_lg     = ent_q[LG_LSB +: 4];
    assign lg_mask  = (32'(e_lg) >= RANK_W) ? '1 : ((RANK_W'(1) << e_lg) - RANK_W'(1));

    always_comb begin
        bc_rank = '0;
        for (int i = 0; i < MAX_FANOUT; i++) begin
            if (step_q == 4'(i)) bc_rank = ent_q[i*RANK_W +: RANK_W];
        end
    end

    always_comb begin
        target = '0;
        case (req_q[37:36])
            2'b00:   target = e_parent;
            2'b01:   target = bc_rank;
            2'b10:   target = (e_local ^ (RANK_W'(1) << step_q)) & lg_mask;
            default: target = (e_local + RANK_W'(1)) & lg_mask;
        endcase
    end

    // The uptree root reports to itself rather than through the rank table.
    assign dst_coord = ((req_q[37:36] == 2'b00) && (e_local == e_parent)) ?
                       MY_COORD : rank_table[target[RA_W-1:0]];
    assign out_tag   = (req_q[37:36] == 2'b10) ? {4'd0, step_q} : req_q[45:38];

    always_comb begin
        out_flit = '0;
        if (state == S_EMIT) begin
            out_flit[53:0]                       = {req_q[53:46], out_tag, req_q[37:0]};
            out_flit[62:54]                      = e_local;
            out_flit[71:63]                      = MY_COORD;
            out_flit[80:72]                      = dst_coord;
            out_flit[81]                         = 1'b1;
            out_flit[FLIT_W+CHILD_W-1:FLIT_W]    = CHILD_W'(e_nch);
        end
    end

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_EMIT);
    assign err       = err_q;

    logic unused_bits;
    assign unused_bits = ^{in_flit[80:54], ent_q[V_BIT], target[RANK_W-1:RA_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            req_q   <= '0;
            ent_q   <= '0;
            count_q <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < COMM_ENTRIES; i++) comm_table[i] <= '0;
            for (int i = 0; i < NUM_PROCS; i++) rank_table[i] <= '0;
        end else begin
            err_q <= 1'b0;
            if (cfg_comm_we) comm_table[cfg_comm_addr] <= cfg_comm_data;
            if (cfg_rank_we) rank_table[cfg_rank_addr] <= cfg_rank_data;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_flit[81]) begin
                        req_q <= in_flit[53:0];
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    ent_q   <= lk_ent;
                    count_q <= lk_count;
                    step_q  <= '0;
                    if (lk_bad) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        step_q <= step_q + 4'd1;
                        if (step_q == count_q - 4'd1) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coll_instr_gen.sv
// Randomised scoreboard bench for coll_instr_gen: a table-level reference model
// predicts every emitted flit and error pulse.
module tb_coll_instr_gen;
    localparam int OW = 85;
    localparam int NE = 4;
    localparam logic [8:0] MY_COORD = 9'd0;

    logic          clk;
    logic          rst;
    logic [81:0]   in_flit;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_flit;
    logic          out_valid;
    logic          out_ready;
    logic          cfg_comm_we;
    logic [1:0]    cfg_comm_addr;
    logic [61:0]   cfg_comm_data;
    logic          cfg_rank_we;
    logic [2:0]    cfg_rank_addr;
    logic [8:0]    cfg_rank_data;
    logic          err;

    coll_instr_gen dut (
        .clk(clk), .rst(rst),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_comm_we(cfg_comm_we), .cfg_comm_addr(cfg_comm_addr), .cfg_comm_data(cfg_comm_data),
        .cfg_rank_we(cfg_rank_we), .cfg_rank_addr(cfg_rank_addr), .cfg_rank_data(cfg_rank_data),
        .err(err)
    );

    logic [OW-1:0] exp_q[$];
    logic          rdy_pat[$];
    bit            ready_rand;
    int            n_vec, n_err, err_seen, err_exp;
    int            m_valid[NE], m_local[NE], m_parent[NE], m_nch[NE], m_lg[NE];
    int            m_child[NE][4];
    int            m_rank[8];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // out_ready driver: scripted pattern first, then random or held high
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
            else if (ready_rand)    out_ready = 1'($urandom_range(0, 1));
            else                    out_ready = 1'b1;
        end
    end

    // monitor / scoreboard
    initial begin
        logic          hold_v;
        logic [OW-1:0] hold_f;
        logic [OW-1:0] e;
        hold_v = 1'b0;
        hold_f = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (err) err_seen++;
                if (out_valid) begin
                    chk("in_ready_busy", OW'(in_ready), OW'(0));
                    if (hold_v) chk("stall_stable", out_flit, hold_f);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_flit: got %h, no flit expected", out_flit);
                        end else begin
                            e = exp_q.pop_front();
                            chk("flit", out_flit, e);
                        end
                    end
                    hold_v = !out_ready;
                    hold_f = out_flit;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic write_comm(input int a, input int v, input int loc, input int par,
                              input int nch, input int lg, input int c0, input int c1,
                              input int c2, input int c3);
        @(negedge clk);
        cfg_comm_we   = 1'b1;
        cfg_comm_addr = 2'(a);
        cfg_comm_data = {1'(v), 9'(loc), 9'(par), 3'(nch), 4'(lg), 9'(c3), 9'(c2), 9'(c1), 9'(c0)};
        m_valid[a] = v; m_local[a] = loc % 512; m_parent[a] = par % 512;
        m_nch[a] = nch % 8; m_lg[a] = lg % 16;
        m_child[a][0] = c0 % 512; m_child[a][1] = c1 % 512;
        m_child[a][2] = c2 % 512; m_child[a][3] = c3 % 512;
        @(negedge clk);
        cfg_comm_we = 1'b0;
    endtask

    task automatic write_rank(input int a, input int v);
        @(negedge clk);
        cfg_rank_we   = 1'b1;
        cfg_rank_addr = 3'(a);
        cfg_rank_data = 9'(v);
        m_rank[a] = v % 512;
        @(negedge clk);
        cfg_rank_we = 1'b0;
    endtask

    task automatic model_push(input int alg, input int ctx, input logic [7:0] tag,
                              input logic [3:0] op, input logic [31:0] pl);
        int cnt, tgt, dst;
        logic [7:0] t;
        cnt = 0;
        if (ctx < NE) begin
            if (m_valid[ctx] != 0) begin
                case (alg)
                    0:       cnt = 1;
                    1:       cnt = m_nch[ctx];
                    2:       cnt = m_lg[ctx];
                    default: cnt = 1;
                endcase
            end
        end
        if (cnt == 0) err_exp++;
        for (int s = 0; s < cnt; s++) begin
            case (alg)
                0:       tgt = m_parent[ctx];
                1:       tgt = (s < 4) ? m_child[ctx][s] : 0;
                2:       tgt = (m_local[ctx] ^ (1 << s)) % (1 << m_lg[ctx]);
                default: tgt = (m_local[ctx] + 1) % (1 << m_lg[ctx]);
            endcase
            if (alg == 0 && m_local[ctx] == m_parent[ctx]) dst = int'(MY_COORD);
            else dst = m_rank[tgt % 8];
            t = (alg == 2) ? 8'(s) : tag;
            exp_q.push_back({3'(m_nch[ctx]), 1'b1, 9'(dst), MY_COORD, 9'(m_local[ctx]),
                             8'(ctx), t, 2'(alg), op, pl});
        end
    endtask

    task automatic send(input logic [81:0] f);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, t);
        end else begin
            in_flit  = f;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic issue(input int alg, input int ctx, input bit vbit);
        logic [7:0]  tag;
        logic [3:0]  op;
        logic [31:0] pl;
        logic [26:0] junk;
        tag  = 8'($urandom);
        op   = 4'($urandom);
        pl   = $urandom;
        junk = 27'($urandom);
        if (vbit) model_push(alg, ctx, tag, op, pl);
        send({vbit, junk, 8'(ctx), tag, 2'(alg), op, pl});
    endtask

    task automatic wait_idle;
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", OW'(exp_q.size()), OW'(0));
        repeat (3) @(negedge clk);
        chk("err_count", OW'(err_seen), OW'(err_exp));
    endtask

    initial begin
        int t;
        n_vec = 0; n_err = 0; err_seen = 0; err_exp = 0;
        ready_rand = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_flit = '0;
        cfg_comm_we = 1'b0; cfg_comm_addr = '0; cfg_comm_data = '0;
        cfg_rank_we = 1'b0; cfg_rank_addr = '0; cfg_rank_data = '0;
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_local[i] = 0; m_parent[i] = 0; m_nch[i] = 0; m_lg[i] = 0;
            for (int j = 0; j < 4; j++) m_child[i][j] = 0;
        end
        for (int i = 0; i < 8; i++) m_rank[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", OW'(in_ready), OW'(0));
        chk("rst_out_valid", OW'(out_valid), OW'(0));
        chk("rst_out_flit", out_flit, OW'(0));
        chk("rst_err", OW'(err), OW'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", OW'(in_ready), OW'(1));

        // uptree with latency check
        write_rank(0, 9'o111);
        write_comm(0, 1, 2, 0, 0, 3, 0, 0, 0, 0);
        issue(0, 0, 1'b1);
        @(negedge clk);
        chk("lat_lookup", OW'(out_valid), OW'(0));
        @(negedge clk);
        chk("lat_emit", OW'(out_valid), OW'(1));
        wait_idle();

        // root uptree goes to own coordinate
        write_comm(2, 1, 0, 0, 2, 3, 0, 0, 0, 0);
        issue(0, 2, 1'b1);
        wait_idle();

        // broadcast under scripted backpressure
        for (int i = 1; i < 8; i++) write_rank(i, i * 41 + 3);
        write_comm(1, 1, 3, 0, 3, 3, 1, 2, 4, 0);
        issue(1, 1, 1'b1);
        @(negedge clk);
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
        wait_idle();

        // recursive doubling; entry rewritten during LOOKUP must not leak in
        write_comm(3, 1, 5, 0, 0, 3, 0, 0, 0, 0);
        issue(2, 3, 1'b1);
        write_comm(3, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        wait_idle();

        // rejected and dropped requests
        write_comm(3, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        issue(0, 3, 1'b1);
        wait_idle();
        issue(0, 200, 1'b1);
        wait_idle();
        write_comm(0, 1, 2, 0, 0, 3, 0, 0, 0, 0);
        issue(1, 0, 1'b1);
        wait_idle();
        issue(0, 0, 1'b0);
        @(negedge clk);
        chk("drop_in_ready", OW'(in_ready), OW'(1));
        wait_idle();

        // ring
        write_comm(2, 1, 7, 0, 0, 3, 0, 0, 0, 0);
        issue(3, 2, 1'b1);
        wait_idle();

        // randomised phase
        ready_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int loc;
            loc = $urandom_range(0, 511);
            if ($urandom_range(0, 2) == 0)
                write_comm($urandom_range(0, 3), ($urandom_range(0, 3) != 0) ? 1 : 0, loc,
                           ($urandom_range(0, 3) == 0) ? loc : $urandom_range(0, 511),
                           $urandom_range(0, 4), $urandom_range(0, 5),
                           $urandom_range(0, 511), $urandom_range(0, 511),
                           $urandom_range(0, 511), $urandom_range(0, 511));
            issue($urandom_range(0, 3), ($urandom_range(0, 5) == 5) ? 200 : $urandom_range(0, 4),
                  ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                write_rank($urandom_range(0, 7), $urandom_range(0, 511));
            end
        end
        wait_idle();
        ready_rand = 1'b0;

        // reset during a stalled broadcast
        write_comm(1, 1, 3, 0, 3, 3, 1, 2, 4, 0);
        issue(1, 1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 12; i++) rdy_pat.push_back(1'b0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("pre_rst_valid", OW'(out_valid), OW'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", OW'(out_valid), OW'(0));
        chk("mid_rst_in_ready", OW'(in_ready), OW'(0));
        chk("mid_rst_out_flit", out_flit, OW'(0));
        exp_q.delete();
        rdy_pat.delete();
        for (int i = 0; i < NE; i++) m_valid[i] = 0;
        for (int i = 0; i < 8; i++) m_rank[i] = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready", OW'(in_ready), OW'(1));
        issue(1, 1, 1'b1);
        wait_idle();
        write_comm(0, 1, 1, 4, 0, 3, 0, 0, 0, 0);
        issue(0, 0, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/coll_instr_gen.md
Name: coll_instr_gen

Overview:
Parametrised collective-instruction generator for the MPI collective router, sitting between the node injection port and the router input FIFO. It accepts one valid collective flit, looks up the communicator and rank tables, and emits a sequence of routed flits with valid/ready handshakes. Supported patterns are uptree (reduce/gather/barrier), tree broadcast, recursive doubling (allreduce) and ring (allgather). Both tables are runtime-writable; nothing is hardcoded.

Parameters:
FLIT_W, 82, flit width; field positions as in the router flit format (payload 31-0, op 35-32, algtype 37-36, tag 45-38, contextId 53-46, rank 62-54, src 71-63, dst 80-72, valid 81)
CHILD_W, 3, width of the children field appended above the flit
NUM_PROCS, 8, rank-table depth (power of 2)
RANK_W, 9, rank and coordinate width (z,y,x 3 bits each)
COMM_ENTRIES, 4, communicator-table depth
MAX_FANOUT, 4, maximum broadcast children per entry
MY_COORD, 9'b0, own {z,y,x}
COMM_W, 26+MAX_FANOUT*RANK_W, communicator entry width: {valid, local_rank, parent_rank, num_children[2:0], lg_commsize[3:0], child[MAX_FANOUT-1:0]}

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_flit  in  FLIT_W  collective request flit
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
out_flit  out  FLIT_W+CHILD_W  generated flit, children field at [FLIT_W+CHILD_W-1:FLIT_W]
out_valid  out  1  out_flit valid
out_ready  in  1  downstream accepts out_flit
cfg_comm_we  in  1  communicator-table write strobe
cfg_comm_addr  in  clog2(COMM_ENTRIES)  communicator-table write index
cfg_comm_data  in  COMM_W  communicator-table write data
cfg_rank_we  in  1  rank-table write strobe
cfg_rank_addr  in  clog2(NUM_PROCS)  rank-table write index
cfg_rank_data  in  RANK_W  physical {z,y,x} coordinates of the rank
err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset: FSM to IDLE; in_ready=0 during rst, 1 on the first cycle after; out_valid=0; out_flit=0; err=0; all table entries cleared (valid=0).
- FSM: IDLE -> LOOKUP -> EMIT -> IDLE.
- IDLE: in_ready=1. On in_valid & in_flit[81], latch the flit and go to LOOKUP. When in_flit[81]=0, consume and drop the flit; stay in IDLE.
- LOOKUP (1 cycle, in_ready=0):
  - Latch the entry at contextId and compute count:
    - algtype 00 uptree: count 1.
    - 01 bcast: count num_children.
    - 10 doubling: count lg_commsize.
    - 11 ring: count 1.
  - If contextId >= COMM_ENTRIES, entry valid=0, or count=0, pulse err and return to IDLE.
  - Otherwise clear step and go to EMIT.
- EMIT: out_valid=1. out_flit is held stable until out_ready.
  - On each out_valid & out_ready: step++. If step==count-1, go to IDLE, with in_ready=1 on the next cycle.
- Target rank per step:
  - uptree: parent_rank; if local_rank==parent_rank (root), dst=MY_COORD.
  - bcast: child[step].
  - doubling: local_rank XOR (1<<step), truncated to lg_commsize bits.
  - ring: (local_rank+1) mod 2^lg_commsize.
- out_flit fields:
  - dst=rank_table[target mod NUM_PROCS]; src=MY_COORD; rank=local_rank.
  - tag = step for doubling, else the input tag.
  - children=num_children; valid=1.
  - payload, op, algtype and contextId are copied from the input.
- Latency: request accepted in cycle T gives first out_valid in T+2. With out_ready held high, one flit per cycle. Minimum request-to-request spacing is count+2 cycles.
- Table writes:
  - Writes take effect the next cycle and are accepted in any state.
  - A write to the address being read in LOOKUP returns the old entry.
  - The communicator entry is snapshotted in LOOKUP; later writes do not affect the in-flight sequence.
  - The rank table is read live during EMIT.
- Reset mid-EMIT: sequence abandoned, out_valid=0 on the next cycle, no partial flush.

Test Plan:
- Uptree: load entry 0 {valid, local 2, parent 0, children 0, lg 3}; rank_table[0]=9'o111; send algtype 00, ctx 0 -> one flit, dst=9'o111, rank=2, children=0, at T+2.
- Root uptree: entry with local=parent=0, MY_COORD=9'o000 -> one flit, dst=9'o000.
- Bcast backpressure: entry children=3 {1,2,4}; out_ready toggles 1,0,0,1,1 -> exactly 3 flits, dst=rank_table[1,2,4] in order, out_flit stable while stalled, in_ready low until the last handshake.
- Doubling: local 5, lg 3 -> 3 flits to ranks 4,7,1 with tag 0,1,2.
- Errors: ctx 3 with valid=0 -> err pulse, no out_valid. Bcast with 0 children -> err. in_flit[81]=0 -> dropped, no err.
- Ring and reset: local 7, lg 3 -> one flit to rank 0. Assert rst mid-bcast -> out_valid=0 the next cycle, tables cleared, in_ready=1 after reset.
